// File: rtl/ntt_butterfly.sv
// Pipelined Cooley-Tukey NTT butterfly: out_sum = (a + w*b) mod Q and
// out_diff = (a - w*b) mod Q. There are three register stages (product,
// Barrett-reduced twiddle product, add/sub). A single stall signal holds
// the whole pipeline whenever the output is occupied and not being taken.

// Combinational Barrett reduction of a 2K-bit product modulo Q.
module barrett_reduction #(
    parameter int Q             = 3329,
    parameter int K             = 12,
    parameter int MU            = 5039,
    parameter int PRODUCT_WIDTH = 2 * K
) (
    input  logic [PRODUCT_WIDTH-1:0] product,
    output logic [K-1:0]             result
);
    localparam int PW = PRODUCT_WIDTH;

    localparam logic [PW-K:0]  MU_W = (PW - K + 1)'(MU);
    localparam logic [PW-K:0]  Q_W  = (PW - K + 1)'(Q);
    localparam logic [K+1:0]   Q_R  = (K + 2)'(Q);

    logic [PW-K:0]  q1;
    logic [PW+1:0]  q1_mu;
    logic [PW-K:0]  q2;
    logic [PW+1:0]  q2_q;
    logic [PW+1:0]  r_full;
    logic [K+1:0]   r0;
    logic [K+1:0]   r1;
    logic [K+1:0]   r2;

    assign q1     = product[PW-1:K-1];
    assign q1_mu  = {{(K + 1){1'b0}}, q1} * {{(K + 1){1'b0}}, MU_W};
    assign q2     = q1_mu[PW+1:K+1];
    assign q2_q   = {{(K + 1){1'b0}}, q2} * {{(K + 1){1'b0}}, Q_W};
    assign r_full = {2'b00, product} - q2_q;

    // The quotient estimate undershoots by at most two, so the remainder is
    // below 3Q and fits in K+2 bits. A second correction step makes the
    // result exact regardless of how tight that bound turns out to be.
    assign r0     = r_full[K+1:0];
    assign r1     = (r0 >= Q_R) ? (r0 - Q_R) : r0;
    assign r2     = (r1 >= Q_R) ? (r1 - Q_R) : r1;
    assign result = r2[K-1:0];
endmodule

module ntt_butterfly #(
    parameter int Q           = 3329,
    parameter int K           = 12,
    parameter int MU          = 5039,
    parameter int COEFF_WIDTH = 12,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COEFF_WIDTH-1:0] in_a,
    input  logic [COEFF_WIDTH-1:0] in_b,
    input  logic [COEFF_WIDTH-1:0] in_w,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COEFF_WIDTH-1:0] out_sum,
    output logic [COEFF_WIDTH-1:0] out_diff,
    output logic [TAG_WIDTH-1:0]   out_tag
);
    localparam logic [K:0] Q_E = (K + 1)'(Q);

    // The whole pipeline moves together. Bubbles stay where they are.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage 1: operand a, tag and the full-width twiddle product.
    logic                 s1_valid_reg;
    logic [K-1:0]         s1_a_reg;
    logic [TAG_WIDTH-1:0] s1_tag_reg;
    logic [2*K-1:0]       s1_prod_reg;
    logic [2*K-1:0]       prod_next;

    assign prod_next = {{K{1'b0}}, in_w} * {{K{1'b0}}, in_b};

    // Stage 1 register: capture a new operand set when the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_tag_reg   <= '0;
            s1_prod_reg  <= '0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg    <= in_a;
                s1_tag_reg  <= in_tag;
                s1_prod_reg <= prod_next;
            end
        end
    end

    // Stage 2: t = (w*b) mod Q from the combinational reducer.
    logic [K-1:0] t_next;

    barrett_reduction #(
        .Q             (Q),
        .K             (K),
        .MU            (MU),
        .PRODUCT_WIDTH (2 * K)
    ) u_barrett (
        .product (s1_prod_reg),
        .result  (t_next)
    );

    logic                 s2_valid_reg;
    logic [K-1:0]         s2_a_reg;
    logic [TAG_WIDTH-1:0] s2_tag_reg;
    logic [K-1:0]         s2_t_reg;

    // Stage 2 register: hold a and the reduced twiddle product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_a_reg     <= '0;
            s2_tag_reg   <= '0;
            s2_t_reg     <= '0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_a_reg   <= s1_a_reg;
                s2_tag_reg <= s1_tag_reg;
                s2_t_reg   <= t_next;
            end
        end
    end

    // Stage 3: modular add and subtract in K+1 bits. The subtraction adds Q
    // first when a < t so that no negative value is ever formed.
    logic [K:0] sum_raw;
    logic [K:0] sum_mod;
    logic [K:0] diff_mod;

    assign sum_raw  = {1'b0, s2_a_reg} + {1'b0, s2_t_reg};
    assign sum_mod  = (sum_raw >= Q_E) ? (sum_raw - Q_E) : sum_raw;
    assign diff_mod = (s2_a_reg >= s2_t_reg)
                    ? ({1'b0, s2_a_reg} - {1'b0, s2_t_reg})
                    : ({1'b0, s2_a_reg} + Q_E - {1'b0, s2_t_reg});

    // Output register: results hold steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_diff  <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_sum  <= sum_mod[K-1:0];
                out_diff <= diff_mod[K-1:0];
                out_tag  <= s2_tag_reg;
            end
        end
    end
endmodule
